scmp_bus_responder: RTL and testbench
=====================================

Name: scmp_bus_responder

Overview:
- Memory-side responder for the SC/MP external bus cycle that the microcode sequencer initiates (ADS/RD/WR strobes plus R/I/D/H status flags).
- Latches the address and status on the address strobe, converts the read or write strobe into a single-cycle request on a simple internal memory port, stretches the CPU cycle with HOLD until the memory acknowledges, then returns read data or captures write data.
- Also reports halt fetches, protocol violations and memory timeouts.

Parameters:
- MIN_WAIT, 1: minimum cycles HOLD stays asserted after the strobe is accepted (0..TIMEOUT).
- TIMEOUT, 15: cycles without mem_ack before the access is aborted (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_ADS_n  in  1  address strobe, active-low
- bus_RD_n  in  1  read strobe, active-low
- bus_WR_n  in  1  write strobe, active-low
- bus_F_R  in  1  status flag: 1 = read cycle
- bus_F_I  in  1  status flag: instruction fetch
- bus_F_D  in  1  status flag: delay cycle
- bus_F_H  in  1  status flag: halt
- bus_addr  in  16  CPU address, valid while bus_ADS_n = 0
- bus_din  in  8  CPU write data, valid while bus_WR_n = 0
- bus_dout  out  8  read data to the CPU
- bus_dout_oe  out  1  read data valid/drive enable
- bus_HOLD  out  1  stretch request, active-high
- mem_addr  out  16  latched address
- mem_rd  out  1  one-cycle read request
- mem_wr  out  1  one-cycle write request
- mem_wdata  out  8  latched write data
- mem_rdata  in  8  memory read data, valid with mem_ack
- mem_ack  in  1  access complete
- stat_flags  out  4  latched {H,D,I,R}
- halt_det  out  1  one-cycle pulse: read with H=1 completed
- err_proto  out  1  one-cycle pulse: protocol violation
- err_timeout  out  1  one-cycle pulse: access timed out

Behaviour:
- All inputs are synchronous to clk; no synchronisers.
- Reset value of every output is 0. The FSM resets to IDLE and the counter to 0.
- FSM states: IDLE, ADDR, RWAIT, RDONE, WWAIT, WDONE.
- IDLE:
  - On bus_ADS_n = 0: latch mem_addr <= bus_addr and stat_flags <= {F_H, F_D, F_I, F_R}, then go to ADDR.
  - If bus_RD_n or bus_WR_n is 0 without ADS: pulse err_proto and stay in IDLE.
- ADDR:
  - bus_ADS_n = 0 again: relatch address and flags, stay in ADDR (previous cycle abandoned).
  - bus_RD_n = 0 with latched R = 1: pulse mem_rd, assert bus_HOLD, clear the counter, go to RWAIT.
  - bus_WR_n = 0 with latched R = 0: mem_wdata <= bus_din, pulse mem_wr, assert bus_HOLD, clear the counter, go to WWAIT.
  - A strobe that mismatches R, or RD_n and WR_n both 0: pulse err_proto, go to IDLE with no memory request.
  - RD/WR takes priority over a simultaneous ADS.
- Request timing: mem_rd/mem_wr rise the cycle after the strobe is sampled and last exactly one cycle. bus_HOLD rises in the same cycle.
- RWAIT/WWAIT:
  - The counter increments each cycle and saturates at TIMEOUT.
  - Completion condition: mem_ack = 1 AND counter >= MIN_WAIT.
  - An ack seen before MIN_WAIT is remembered in a sticky bit. Read data is captured into bus_dout when the ack occurs.
  - On completion: drop bus_HOLD next cycle.
    - Read: bus_dout <= mem_rdata (or the sticky copy), bus_dout_oe <= 1, go to RDONE.
    - Write: go to WDONE.
  - Timeout: counter reaches TIMEOUT with no ack. Pulse err_timeout and drop bus_HOLD.
    - Read: bus_dout <= 8'hFF with bus_dout_oe <= 1, go to RDONE.
    - Write: go to WDONE.
  - An ack arriving after a timeout is ignored.
- RDONE:
  - Hold bus_dout and bus_dout_oe while bus_RD_n = 0.
  - When bus_RD_n = 1: bus_dout_oe <= 0 and go to IDLE.
  - On entry, if latched H = 1, pulse halt_det once (also after a timeout).
- WDONE: stay until bus_WR_n = 1, then go to IDLE.
- Strobe released early (in RWAIT or WWAIT): finish the memory wait normally, then return to IDLE without asserting bus_dout_oe.
- ADS in any state other than IDLE/ADDR: pulse err_proto, ignore the strobe.
- Latency with ack at the earliest legal cycle and MIN_WAIT = 1: RD_n low to bus_dout_oe high is 3 cycles.
- Counter width: $clog2(TIMEOUT+1).
- Reset mid-operation: asynchronously clears all state and outputs, including bus_HOLD. No memory request is issued after reset.

Test Plan:
- Read: ADS with addr 16'h1234 and R=1, then RD_n low; mem_ack 2 cycles after mem_rd with rdata 8'hA5 -> mem_rd single pulse, mem_addr 16'h1234, HOLD high until ack, bus_dout 8'hA5 with oe while RD_n low, IDLE after RD_n rises.
- Write: ADS with addr 16'h0F00 and R=0, WR_n low with din 8'h3C, immediate ack, MIN_WAIT=1 -> one mem_wr pulse, mem_wdata 8'h3C, HOLD exactly 1 cycle after ack, no err pulses.
- Timeout: read with mem_ack held 0, TIMEOUT=15 -> err_timeout pulses once 15 cycles after mem_rd, bus_dout 8'hFF, HOLD released; a later mem_ack is ignored.
- Protocol: RD_n low in IDLE, and WR_n low after ADS with R=1 -> err_proto pulse each time, no mem_rd/mem_wr, FSM returns to IDLE.
- Halt: read with flags H=1, I=1, R=1 and ack 8'h00 -> stat_flags 4'b1011, halt_det single pulse on RDONE entry.
- Reset: assert rst_n low during RWAIT with HOLD high -> HOLD, oe and mem_rd go to 0 immediately; after release a fresh read completes normally.

Source files
------------

// File: rtl/scmp_bus_responder_if.sv
// SC/MP external bus cycle plus the internal single-cycle memory port, as seen by the bus responder.
// The master side is the CPU and memory environment; the slave side is the responder.
interface scmp_bus_responder_if;
    logic        bus_ADS_n;
    logic        bus_RD_n;
    logic        bus_WR_n;
    logic        bus_F_R;
    logic        bus_F_I;
    logic        bus_F_D;
    logic        bus_F_H;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic [7:0]  bus_dout;
    logic        bus_dout_oe;
    logic        bus_HOLD;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  stat_flags;
    logic        halt_det;
    logic        err_proto;
    logic        err_timeout;

    modport master (
        output bus_ADS_n, bus_RD_n, bus_WR_n, bus_F_R, bus_F_I, bus_F_D, bus_F_H,
               bus_addr, bus_din, mem_rdata, mem_ack,
        input  bus_dout, bus_dout_oe, bus_HOLD, mem_addr, mem_rd, mem_wr, mem_wdata,
               stat_flags, halt_det, err_proto, err_timeout
    );

    modport slave (
        input  bus_ADS_n, bus_RD_n, bus_WR_n, bus_F_R, bus_F_I, bus_F_D, bus_F_H,
               bus_addr, bus_din, mem_rdata, mem_ack,
        output bus_dout, bus_dout_oe, bus_HOLD, mem_addr, mem_rd, mem_wr, mem_wdata,
               stat_flags, halt_det, err_proto, err_timeout
    );
endinterface

// File: rtl/scmp_bus_responder.sv
// Memory-side responder for the SC/MP bus cycle: latches address/status on ADS, turns RD/WR into a
// one-cycle memory request, stretches the CPU with HOLD until ack or timeout, and flags halts and errors.
module scmp_bus_responder #(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scmp_bus_responder_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MIN  = cnt_t'(MIN_WAIT);
    localparam cnt_t CNT_MAX  = cnt_t'(TIMEOUT);
    localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RWAIT,
        RDONE,
        WWAIT,
        WDONE
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  flags;       // {H, D, I, R}
        logic [7:0]  wdata;
        logic [7:0]  dout;
        logic        dout_oe;
        logic        hold;
        logic        mem_rd;
        logic        mem_wr;
        logic        halt_det;
        logic        err_proto;
        logic        err_timeout;
        cnt_t        cnt;
        logic        ack_seen;
        logic        released;
    } regs_t;

    state_t state_q, state_d;
    regs_t  r_q, r_d;

    logic ads, rd, wr;
    logic strobe, left_early;
    logic got_ack, min_ok, done, tmo;

    assign ads = ~bus.bus_ADS_n;
    assign rd  = ~bus.bus_RD_n;
    assign wr  = ~bus.bus_WR_n;

    // The strobe that opened the current wait; once it drops, the cycle ends without driving data.
    assign strobe     = (state_q == RWAIT) ? rd : wr;
    assign left_early = r_q.released | ~strobe;

    assign got_ack = bus.mem_ack | r_q.ack_seen;
    assign min_ok  = (r_q.cnt >= CNT_MIN);
    assign done    = got_ack & min_ok;
    assign tmo     = ~got_ack & (r_q.cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every bit; a missing branch would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ads) state_d = ADDR;
            end
            ADDR: begin
                if (rd && !wr && r_q.flags[0])       state_d = RWAIT;
                else if (wr && !rd && !r_q.flags[0]) state_d = WWAIT;
                else if (rd || wr)                   state_d = IDLE;
            end
            RWAIT: begin
                if (done || tmo) state_d = left_early ? IDLE : RDONE;
            end
            WWAIT: begin
                if (done || tmo) state_d = left_early ? IDLE : WDONE;
            end
            RDONE: begin
                if (!rd) state_d = IDLE;
            end
            WDONE: begin
                if (!wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_d             = r_q;
        r_d.mem_rd      = 1'b0;
        r_d.mem_wr      = 1'b0;
        r_d.halt_det    = 1'b0;
        r_d.err_proto   = 1'b0;
        r_d.err_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (ads) begin
                    r_d.addr  = bus.bus_addr;
                    r_d.flags = {bus.bus_F_H, bus.bus_F_D, bus.bus_F_I, bus.bus_F_R};
                end else if (rd || wr) begin
                    r_d.err_proto = 1'b1;
                end
            end
            ADDR: begin
                // A data strobe wins over a simultaneous ADS; a repeated ADS alone abandons the cycle.
                if (rd && !wr && r_q.flags[0]) begin
                    r_d.mem_rd   = 1'b1;
                    r_d.hold     = 1'b1;
                    r_d.cnt      = '0;
                    r_d.ack_seen = 1'b0;
                    r_d.released = 1'b0;
                end else if (wr && !rd && !r_q.flags[0]) begin
                    r_d.wdata    = bus.bus_din;
                    r_d.mem_wr   = 1'b1;
                    r_d.hold     = 1'b1;
                    r_d.cnt      = '0;
                    r_d.ack_seen = 1'b0;
                    r_d.released = 1'b0;
                end else if (rd || wr) begin
                    r_d.err_proto = 1'b1;
                end else if (ads) begin
                    r_d.addr  = bus.bus_addr;
                    r_d.flags = {bus.bus_F_H, bus.bus_F_D, bus.bus_F_I, bus.bus_F_R};
                end
            end
            RWAIT, WWAIT: begin
                r_d.err_proto = ads;
                if (r_q.cnt != CNT_MAX) r_d.cnt = r_q.cnt + cnt_t'(1);
                if (!strobe) r_d.released = 1'b1;
                // An early ack is kept until the minimum wait has elapsed; its data goes straight to bus_dout.
                if (bus.mem_ack && !min_ok) r_d.ack_seen = 1'b1;
                if (state_q == RWAIT && bus.mem_ack) r_d.dout = bus.mem_rdata;
                if (done || tmo) begin
                    r_d.hold        = 1'b0;
                    r_d.err_timeout = tmo;
                    if (state_q == RWAIT) begin
                        r_d.halt_det = r_q.flags[3];
                        r_d.dout_oe  = ~left_early;
                        if (tmo) r_d.dout = 8'hFF;
                    end
                end
            end
            RDONE: begin
                r_d.err_proto = ads;
                if (!rd) r_d.dout_oe = 1'b0;
            end
            WDONE: begin
                r_d.err_proto = ads;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: there is no memory array here, so the whole datapath is reset and every output starts at 0.
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign bus.mem_addr    = r_q.addr;
    assign bus.stat_flags  = r_q.flags;
    assign bus.mem_wdata   = r_q.wdata;
    assign bus.bus_dout    = r_q.dout;
    assign bus.bus_dout_oe = r_q.dout_oe;
    assign bus.bus_HOLD    = r_q.hold;
    assign bus.mem_rd      = r_q.mem_rd;
    assign bus.mem_wr      = r_q.mem_wr;
    assign bus.halt_det    = r_q.halt_det;
    assign bus.err_proto   = r_q.err_proto;
    assign bus.err_timeout = r_q.err_timeout;
endmodule

// File: tb/tb_scmp_bus_responder.sv
// Randomized bench for scmp_bus_responder: the expected timing of each bus cycle is computed from the
// ack delay, MIN_WAIT and TIMEOUT, and every cycle of the transaction is compared against it.
module tb_scmp_bus_responder;
    localparam int MIN_WAIT = 1;
    localparam int TIMEOUT  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    scmp_bus_responder_if bus_if ();

    scmp_bus_responder #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.bus_ADS_n = 1'b1;
        bus_if.bus_RD_n  = 1'b1;
        bus_if.bus_WR_n  = 1'b1;
        bus_if.mem_ack   = 1'b0;
        bus_if.bus_addr  = 16'($urandom);
        bus_if.bus_din   = 8'($urandom);
        bus_if.mem_rdata = 8'($urandom);
        bus_if.bus_F_R   = 1'($urandom);
        bus_if.bus_F_I   = 1'($urandom);
        bus_if.bus_F_D   = 1'($urandom);
        bus_if.bus_F_H   = 1'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({bus_if.mem_rd, bus_if.mem_wr, bus_if.bus_HOLD,
                        bus_if.err_proto, bus_if.err_timeout, bus_if.halt_det}), 0);
    endtask

    task automatic do_ads(input logic [15:0] addr, input logic [3:0] fl);
        bus_if.bus_ADS_n = 1'b0;
        bus_if.bus_addr  = addr;
        {bus_if.bus_F_H, bus_if.bus_F_D, bus_if.bus_F_I, bus_if.bus_F_R} = fl;
        tick();
        bus_if.bus_ADS_n = 1'b1;
        bus_if.bus_addr  = 16'($urandom);
        {bus_if.bus_F_H, bus_if.bus_F_D, bus_if.bus_F_I, bus_if.bus_F_R} = 4'($urandom);
    endtask

    // Memory acks d cycles after the mem_rd cycle (d = 0: during it). The wait ends on the edge
    // 1 + max(d, MIN_WAIT) after the strobe, or on edge TIMEOUT when no ack arrives in time.
    task automatic run_read(input logic [15:0] addr, input logic [2:0] hdi, input int d,
                            input logic [7:0] rdata, input int hold_rd, input bit early,
                            input bit dbl, input bit ads_mid);
        logic [3:0] fl;
        bit         to;
        int         c;
        int         mid_k;
        fl    = {hdi, 1'b1};
        to    = (d >= TIMEOUT);
        c     = to ? TIMEOUT : 1 + ((d > MIN_WAIT) ? d : MIN_WAIT);
        mid_k = (ads_mid && c >= 2) ? 2 : 0;
        if (dbl) begin
            do_ads(~addr, {hdi, 1'b0});
            check_quiet("rd_ads1_quiet");
        end
        do_ads(addr, fl);
        check("rd_addr", 32'(bus_if.mem_addr), 32'(addr));
        check("rd_flags", 32'(bus_if.stat_flags), 32'(fl));
        check_quiet("rd_ads_quiet");
        bus_if.bus_RD_n = 1'b0;
        tick();
        for (int k = 1; k <= c; k++) begin
            check("rd_req", 32'(bus_if.mem_rd), 32'(k == 1));
            check("rd_hold", 32'(bus_if.bus_HOLD), 1);
            check("rd_oe_wait", 32'(bus_if.bus_dout_oe), 0);
            check("rd_flags_wait", 32'({bus_if.err_proto, bus_if.err_timeout, bus_if.halt_det, bus_if.mem_wr}),
                  32'({k == mid_k, 3'b000}));
            bus_if.mem_ack   = (k == d + 1);
            bus_if.mem_rdata = (k == d + 1) ? rdata : 8'($urandom);
            bus_if.bus_ADS_n = !(mid_k != 0 && k == 1);
            if (early && k == 1) bus_if.bus_RD_n = 1'b1;
            tick();
        end
        check("rd_hold_end", 32'(bus_if.bus_HOLD), 0);
        check("rd_req_end", 32'(bus_if.mem_rd), 0);
        check("rd_timeout", 32'(bus_if.err_timeout), 32'(to));
        check("rd_oe_on", 32'(bus_if.bus_dout_oe), 32'(!early));
        check("rd_proto_end", 32'(bus_if.err_proto), 0);
        if (!early) begin
            check("rd_halt", 32'(bus_if.halt_det), 32'(fl[3]));
            check("rd_data", 32'(bus_if.bus_dout), to ? 32'hFF : 32'(rdata));
        end
        bus_if.mem_ack   = to;
        bus_if.mem_rdata = 8'($urandom);
        if (!early) begin
            for (int j = 0; j < hold_rd; j++) begin
                tick();
                bus_if.mem_ack = 1'b0;
                check("rd_oe_hold", 32'(bus_if.bus_dout_oe), 1);
                check("rd_data_hold", 32'(bus_if.bus_dout), to ? 32'hFF : 32'(rdata));
                check_quiet("rd_hold_quiet");
            end
        end
        bus_if.bus_RD_n = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        check("rd_oe_off", 32'(bus_if.bus_dout_oe), 0);
        check_quiet("rd_end_quiet");
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [2:0] hdi, input logic [7:0] din,
                             input int d, input int hold_wr, input bit early);
        logic [3:0] fl;
        bit         to;
        int         c;
        fl = {hdi, 1'b0};
        to = (d >= TIMEOUT);
        c  = to ? TIMEOUT : 1 + ((d > MIN_WAIT) ? d : MIN_WAIT);
        do_ads(addr, fl);
        check("wr_addr", 32'(bus_if.mem_addr), 32'(addr));
        check("wr_flags", 32'(bus_if.stat_flags), 32'(fl));
        bus_if.bus_din  = din;
        bus_if.bus_WR_n = 1'b0;
        tick();
        for (int k = 1; k <= c; k++) begin
            check("wr_req", 32'(bus_if.mem_wr), 32'(k == 1));
            check("wr_wdata", 32'(bus_if.mem_wdata), 32'(din));
            check("wr_hold", 32'(bus_if.bus_HOLD), 1);
            check("wr_others", 32'({bus_if.mem_rd, bus_if.bus_dout_oe, bus_if.err_proto,
                                    bus_if.err_timeout, bus_if.halt_det}), 0);
            bus_if.mem_ack   = (k == d + 1);
            bus_if.mem_rdata = 8'($urandom);
            if (early && k == 1) begin
                bus_if.bus_WR_n = 1'b1;
                bus_if.bus_din  = 8'($urandom);
            end
            tick();
        end
        check("wr_hold_end", 32'(bus_if.bus_HOLD), 0);
        check("wr_req_end", 32'(bus_if.mem_wr), 0);
        check("wr_timeout", 32'(bus_if.err_timeout), 32'(to));
        check("wr_others_end", 32'({bus_if.mem_rd, bus_if.bus_dout_oe, bus_if.err_proto, bus_if.halt_det}), 0);
        bus_if.mem_ack = to;
        if (!early) begin
            for (int j = 0; j < hold_wr; j++) begin
                tick();
                bus_if.mem_ack = 1'b0;
                check_quiet("wr_hold_quiet");
                check("wr_wdata_hold", 32'(bus_if.mem_wdata), 32'(din));
            end
        end
        bus_if.bus_WR_n = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        check_quiet("wr_end_quiet");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_addr", 32'(bus_if.mem_addr), 0);
        check("reset_flags", 32'(bus_if.stat_flags), 0);
        check("reset_data", 32'({bus_if.bus_dout, bus_if.mem_wdata, bus_if.bus_dout_oe}), 0);
        check_quiet("reset_quiet");
        rst_n = 1'b1;
        tick();

        // Directed reads: nominal, earliest ack (3-cycle latency), last legal ack, timeout with late ack.
        run_read(16'h1234, 3'b000, 2, 8'hA5, 2, 1'b0, 1'b0, 1'b0);
        run_read(16'h2222, 3'b000, 0, 8'h5A, 1, 1'b0, 1'b0, 1'b0);
        run_read(16'h3333, 3'b010, TIMEOUT - 1, 8'hC3, 0, 1'b0, 1'b0, 1'b0);
        run_read(16'h4000, 3'b000, TIMEOUT + 2, 8'h11, 2, 1'b0, 1'b0, 1'b0);
        run_write(16'h0F00, 3'b000, 8'h3C, 0, 1, 1'b0);
        run_write(16'h0F01, 3'b000, 8'h77, TIMEOUT, 1, 1'b0);

        // Halt fetch: {H,D,I,R} = 1011 with ack data 00.
        run_read(16'h0100, 3'b101, 1, 8'h00, 1, 1'b0, 1'b0, 1'b0);

        // Early strobe release, ADS relatch in ADDR, ADS during a wait.
        run_read(16'h5000, 3'b100, 3, 8'h99, 0, 1'b1, 1'b0, 1'b0);
        run_write(16'h5001, 3'b000, 8'h42, 2, 0, 1'b1);
        run_read(16'h6000, 3'b000, 1, 8'h66, 1, 1'b0, 1'b1, 1'b1);

        // Protocol: data strobe in IDLE.
        bus_if.bus_RD_n = 1'b0;
        tick();
        check("proto_idle_err", 32'(bus_if.err_proto), 1);
        check("proto_idle_req", 32'({bus_if.mem_rd, bus_if.mem_wr, bus_if.bus_HOLD}), 0);
        bus_if.bus_RD_n = 1'b1;
        tick();
        check_quiet("proto_idle_after");

        // Protocol: write strobe after a read-flagged ADS, then prove the FSM is back in IDLE.
        do_ads(16'h7000, 4'b0001);
        bus_if.bus_WR_n = 1'b0;
        tick();
        check("proto_wr_err", 32'(bus_if.err_proto), 1);
        check("proto_wr_req", 32'({bus_if.mem_rd, bus_if.mem_wr, bus_if.bus_HOLD}), 0);
        bus_if.bus_WR_n = 1'b1;
        bus_if.bus_RD_n = 1'b0;
        tick();
        check("proto_back_idle", 32'({bus_if.err_proto, bus_if.mem_rd}), 32'b10);
        bus_if.bus_RD_n = 1'b1;
        tick();

        // Protocol: both strobes low after ADS.
        do_ads(16'h7100, 4'b0000);
        bus_if.bus_RD_n = 1'b0;
        bus_if.bus_WR_n = 1'b0;
        tick();
        check("proto_both_err", 32'(bus_if.err_proto), 1);
        check("proto_both_req", 32'({bus_if.mem_rd, bus_if.mem_wr, bus_if.bus_HOLD}), 0);
        drive_idle();
        tick();
        check_quiet("proto_both_after");

        // Reset in the middle of a read wait.
        do_ads(16'hBEEF, 4'b0001);
        bus_if.bus_RD_n = 1'b0;
        tick();
        check("rst_pre_hold", 32'(bus_if.bus_HOLD), 1);
        check("rst_pre_req", 32'(bus_if.mem_rd), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_hold", 32'(bus_if.bus_HOLD), 0);
        check("rst_mid_oe", 32'(bus_if.bus_dout_oe), 0);
        check("rst_mid_req", 32'(bus_if.mem_rd), 0);
        check("rst_mid_addr", 32'(bus_if.mem_addr), 0);
        drive_idle();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("rst_after_quiet");
        end
        run_read(16'h5678, 3'b000, 1, 8'h3E, 1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 0)
                run_read(16'($urandom), 3'($urandom), d, 8'($urandom), int'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 5) == 0));
            else
                run_write(16'($urandom), 3'($urandom), 8'($urandom), d, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0));
            drive_idle();
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_quiet("gap_quiet");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
